hicore_ifetch: RTL and testbench

HICORE_IFETCH -- requirements
Module: HiCore_ifetch

---
 rtl/hicore_ifetch.sv | 113 +++++++++++
 tb/tb_hicore_ifetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hicore_ifetch.sv
// rtl/hicore_ifetch.sv - instruction fetch unit with 2-slot request/response window and redirect squash
module hicore_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam logic [2:0] LP_DEPTH = 3'(DEPTH);

    logic [31:0] r_fetch_pc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;
    logic [1:0]  r_fifo_count;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic        r_fifo_rd;
    logic        r_fifo_wr;
    logic [31:0] r_inf_pc     [2];
    logic        r_inf_rd;
    logic        r_inf_wr;

    logic [2:0]  w_slots;
    logic        w_req;
    logic        w_grant;
    logic        w_rsp;
    logic        w_keep;
    logic        w_if_valid;
    logic        w_pop;
    logic [1:0]  w_out_after_rsp;

    // A slot is either a request still on the bus or an instruction waiting in the FIFO.
    assign w_slots         = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_req           = ~rst & ~branch & (w_slots < LP_DEPTH);
    assign w_grant         = w_req & ibus_gnt;
    assign w_rsp           = ibus_rvalid & (r_outstanding != 2'd0);
    assign w_keep          = w_rsp & (r_drop == 2'd0) & ~branch;
    assign w_if_valid      = ~rst & (r_fifo_count != 2'd0);
    assign w_pop           = w_if_valid & if_ready & ~branch;
    assign w_out_after_rsp = r_outstanding - {1'b0, w_rsp};

    assign ibus_req  = w_req;
    assign ibus_addr = rst ? RESET_PC : r_fetch_pc;
    assign if_valid  = w_if_valid;
    assign if_pc     = w_if_valid ? r_fifo_pc[r_fifo_rd]    : 32'h0;
    assign if_instr  = w_if_valid ? r_fifo_instr[r_fifo_rd] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
            r_fifo_count  <= 2'd0;
            r_fifo_rd     <= 1'b0;
            r_fifo_wr     <= 1'b0;
            r_inf_rd      <= 1'b0;
            r_inf_wr      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= 32'h0;
                r_fifo_instr[i] <= 32'h0;
                r_inf_pc[i]     <= 32'h0;
            end
        end else begin
            r_outstanding <= w_out_after_rsp + {1'b0, w_grant};

            // The in-flight PC queue advances on every accepted response, stale or not.
            if (w_grant) begin
                r_inf_pc[r_inf_wr] <= r_fetch_pc;
                r_inf_wr           <= ~r_inf_wr;
            end
            if (w_rsp) begin
                r_inf_rd <= ~r_inf_rd;
            end

            if (branch) begin
                r_fetch_pc   <= {branch_pc[31:2], 2'b00};
                r_drop       <= w_out_after_rsp;
                r_fifo_count <= 2'd0;
                r_fifo_rd    <= 1'b0;
                r_fifo_wr    <= 1'b0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
                if (w_keep) begin
                    r_fifo_pc[r_fifo_wr]    <= r_inf_pc[r_inf_rd];
                    r_fifo_instr[r_fifo_wr] <= ibus_rdata;
                    r_fifo_wr               <= ~r_fifo_wr;
                end
                if (w_pop) begin
                    r_fifo_rd <= ~r_fifo_rd;
                end
                r_fifo_count <= r_fifo_count + {1'b0, w_keep} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_hicore_ifetch.sv
// tb/tb_hicore_ifetch.sv - scoreboard bench for hicore_ifetch against a transaction-level fetch model
module tb_hicore_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        branch;
    logic [31:0] branch_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    hicore_ifetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_gnt   (ibus_gnt),
        .ibus_rvalid(ibus_rvalid),
        .ibus_rdata (ibus_rdata),
        .branch     (branch),
        .branch_pc  (branch_pc),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_ready   (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Bus-side view: requests granted but not yet answered; program-side view: words owed to dispatch.
    req_t        bus_q[$];
    ent_t        exp_q[$];
    logic [31:0] exp_fetch;

    int tests = 0;
    int fails = 0;
    int consumed = 0;
    int first_after_branch = 0;
    int p_gnt, p_rvalid, p_ready, p_branch, p_stray;
    logic        force_rst;
    logic        force_branch;
    logic [31:0] force_branch_pc;
    logic        running = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        req_t r;
        ent_t e;
        logic exp_req;
        @(posedge clk);
        #1;
        rst         = force_rst;
        branch      = force_branch | (!force_rst && ($urandom_range(99) < p_branch));
        branch_pc   = force_branch ? force_branch_pc : $urandom;
        ibus_gnt    = $urandom_range(99) < p_gnt;
        if_ready    = $urandom_range(99) < p_ready;
        ibus_rvalid = (bus_q.size() > 0) ? ($urandom_range(99) < p_rvalid)
                                         : ($urandom_range(99) < p_stray);
        ibus_rdata  = $urandom;
        #2;
        if (rst) begin
            check("rst_ibus_req", {31'h0, ibus_req}, 32'h0);
            check("rst_ibus_addr", ibus_addr, RESET_PC);
            check("rst_if_valid", {31'h0, if_valid}, 32'h0);
            check("rst_if_pc", if_pc, 32'h0);
            check("rst_if_instr", if_instr, 32'h0);
            bus_q.delete();
            exp_q.delete();
            exp_fetch = RESET_PC;
        end else begin
            exp_req = !branch && ((bus_q.size() + exp_q.size()) < 2);
            check("ibus_req", {31'h0, ibus_req}, {31'h0, exp_req});
            check("ibus_addr", ibus_addr, exp_fetch);
            check("if_valid", {31'h0, if_valid}, {31'h0, exp_q.size() != 0});
            if (ibus_rvalid && bus_q.size() > 0) begin
                r = bus_q.pop_front();
                if (!r.stale && !branch) begin
                    e.pc    = r.pc;
                    e.instr = ibus_rdata;
                    exp_q.push_back(e);
                end
            end
            if (ibus_req && ibus_gnt) begin
                r.pc    = exp_fetch;
                r.stale = 1'b0;
                bus_q.push_back(r);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (branch) begin
                foreach (bus_q[i]) bus_q[i].stale = 1'b1;
                exp_q.delete();
                exp_fetch = {branch_pc[31:2], 2'b00};
            end
        end
    endtask

    // Monitor: whatever dispatch is shown must be the oldest word still owed.
    always @(negedge clk) begin
        ent_t e;
        if (running && !rst && !branch && if_valid) begin
            if (exp_q.size() == 0) begin
                check("if_unexpected", {31'h0, if_valid}, 32'h0);
            end else begin
                e = exp_q[0];
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
                if (first_after_branch == 1) begin
                    check("first_pc_after_branch", if_pc, 32'h0000_0100);
                    first_after_branch = 2;
                end
                if (if_ready) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
            end
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
        branch = 1'b0; branch_pc = 32'h0; if_ready = 1'b0;
        force_rst = 1'b1; force_branch = 1'b0; force_branch_pc = 32'h0;
        exp_fetch = RESET_PC;
        p_gnt = 100; p_rvalid = 100; p_ready = 100; p_branch = 0; p_stray = 0;
        running = 1'b1;
        run(3);

        force_rst = 1'b0;
        run(20);

        p_ready = 0;
        run(10);
        p_ready = 100;
        run(10);

        p_rvalid = 0;
        run(4);
        force_branch = 1'b1; force_branch_pc = 32'h0000_0103;
        first_after_branch = 1;
        cycle();
        force_branch = 1'b0;
        p_rvalid = 100;
        run(10);
        check("branch_target_consumed", first_after_branch, 2);

        force_branch = 1'b1; force_branch_pc = 32'hFFFF_FFFE;
        cycle();
        force_branch = 1'b0;
        run(6);

        p_rvalid = 0; p_ready = 0;
        run(3);
        p_rvalid = 100;
        run(2);
        p_rvalid = 0;
        run(2);
        force_rst = 1'b1;
        cycle();
        force_rst = 1'b0; p_gnt = 0; p_stray = 100;
        run(5);

        p_gnt = 60; p_rvalid = 50; p_ready = 60; p_branch = 5; p_stray = 5;
        for (int i = 0; i < 3000; i++) begin
            force_rst = ($urandom_range(199) == 0);
            cycle();
        end
        force_rst = 1'b0;

        tests++;
        if (consumed < 200) begin
            fails++;
            $display("FAIL progress: consumed %0d instructions, required at least 200", consumed);
        end

        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
